dt_node_walker: RTL and testbench
=================================

# dt_node_walker

Table-driven sequential decision-tree evaluator for the dt classifier family. It accepts a 10-bit binary feature vector over a valid/ready handshake and walks a tree held in a writable node table, visiting one node per clock. It returns a 1-bit class plus an error flag. It reads the same tree topology that the generated combinational classifiers hard-wire, so a tree can be loaded at run time and compared against its fixed-logic counterpart.

## Interface
Parameters:
- N_FEAT, 10, width of the feature vector.
- DEPTH, 32, number of node-table entries; address width is 5.
- MAX_STEPS, 16, maximum number of internal nodes visited per walk before an error is declared.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  5  entry to write.
- cfg_wdata  in  16  entry value.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  walker can accept a vector.
- inp  in  N_FEAT  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- outp  out  1  class result.
- out_err  out  1  walk error: bad feature index or step limit reached.
- busy  out  1  high in WALK or DONE.

## Operation
- Entry encoding:
  - [0] leaf.
  - [1] leaf value.
  - [5:2] feature index k.
  - [10:6] child when inp[k]=0.
  - [15:11] child when inp[k]=1.
- The root is always entry 0.
- Node table:
  - Built from flops, read asynchronously.
  - Reset sets every entry to 16'h0001, a leaf with value 0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch inp into a feature register, set ptr=0 and step=0, go to WALK.
  - WALK: evaluate entry[ptr] each cycle, in this priority:
    - Leaf: outp=leaf value, out_err=0, go to DONE.
    - k ≥ N_FEAT: outp=0, out_err=1, go to DONE.
    - step == MAX_STEPS-1: outp=0, out_err=1, go to DONE.
    - Otherwise: ptr=selected child, step=step+1.
  - DONE:
    - out_valid=1; outp and out_err are held stable.
    - On out_ready, go to IDLE.
- Config writes:
  - Honoured only in IDLE.
  - cfg_we in WALK or DONE is dropped silently, with no side effect.
  - A write in the same cycle as an accept is still applied, because the FSM is in IDLE that cycle. The walk starting next cycle sees the new value.
- The feature register is the only source of feature bits during a walk. Changes on inp after accept have no effect.
- outp and out_err keep their last values outside DONE and are only meaningful while out_valid=1.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, outp=0, out_err=0, busy=0.
  - ptr=0, step=0.
  - Node table at its reset contents.
- Latency:
  - Count the accept edge as cycle 0.
  - A path that traverses d internal nodes before reaching a leaf asserts out_valid from cycle d+2.
  - A root leaf gives out_valid at cycle 2.
- Step limit: a walk that hits the limit asserts out_valid at cycle MAX_STEPS+1, which is 17 at the default.
- Handshakes:
  - in_ready is combinational from state (IDLE only). No input is accepted while a walk or result is pending.
  - out_valid holds until out_ready is sampled high. The following cycle is IDLE, with in_ready=1.
  - Throughput is at most one vector every d+3 cycles.
- Backpressure: out_ready may be held low indefinitely; the result is held unchanged.
- Reset mid-operation:
  - Asserting rst_n low at any point aborts the walk immediately.
  - out_valid drops asynchronously.
  - The node table returns to its reset contents.

## Test plan
- Reset defaults: after reset, send inp=10'h3FF. Expect out_valid at cycle 2 with outp=0 and out_err=0.
- Three-node tree: program entry0=(feature 1, child0=1, child1=2), entry1=leaf 1, entry2=leaf 0.
  - inp=10'h000: expect outp=1 at cycle 3.
  - inp=10'h002: expect outp=0 at cycle 3.
- Loop: program entry0 as internal, feature 0, both children 0. Expect out_err=1 and outp=0, with out_valid first high at cycle 17.
- Bad feature: program entry0 with k=12. Expect out_err=1 at cycle 2.
- Backpressure and ignored config:
  - Hold out_ready=0 for 10 cycles while pulsing cfg_we (entry1=leaf 0) during WALK and DONE.
  - Expect the result held stable and in_ready=0 throughout.
  - Expect a re-run to still return outp=1, showing the write was dropped.
- Reset mid-walk: in the loop configuration, pull rst_n low at cycle 5.
  - Expect out_valid=0 and in_ready=1 after release.
  - Expect a new vector to walk the reset table and return outp=0 at cycle 2.

Source files
------------

// File: rtl/dt_node_walker.sv
// Sequential decision-tree walker over a writable flop-based node table.
// Ports: cfg_* table writes, in_* vector handshake, out_* result handshake.
module dt_node_walker #(
  parameter int N_FEAT    = 10,
  parameter int DEPTH     = 32,
  parameter int MAX_STEPS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [15:0]              cfg_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT-1:0]        inp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     outp,
  output logic                     out_err,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_STEPS);
  localparam logic [4:0] NF = 5'(N_FEAT);
  localparam logic [SW-1:0] LAST = SW'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  state_t             state;
  logic [15:0]        tbl [DEPTH];
  logic [N_FEAT-1:0]  feat;
  logic [AW-1:0]      ptr;
  logic [SW-1:0]      step;

  logic [15:0]        node;
  logic [3:0]         k;
  logic [N_FEAT+15:0] fx;
  logic               fbit;
  logic               is_leaf;
  logic               bad_k;
  logic               at_lim;
  logic               go_on;
  logic [4:0]         child;

  assign node = tbl[ptr];
  assign k    = node[5:2];
  // zero-extended copy keeps any 4-bit index in range
  assign fx   = {16'b0, feat};
  assign fbit = fx[k];

  // mutually exclusive terms encode the evaluation priority
  assign is_leaf = node[0];
  assign bad_k   = !is_leaf && ({1'b0, k} >= NF);
  assign at_lim  = !is_leaf && !bad_k && (step == LAST);
  assign go_on   = !is_leaf && !bad_k && !at_lim;
  assign child   = fbit ? node[15:11] : node[10:6];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      feat      <= '0;
      ptr       <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      outp      <= 1'b0;
      out_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= 16'h0001;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            tbl[cfg_addr] <= cfg_wdata;
          end
          if (in_valid) begin
            feat  <= inp;
            ptr   <= '0;
            step  <= '0;
            state <= WALK;
          end
        end
        WALK: begin
          unique case (1'b1)
            is_leaf: begin
              outp      <= node[1];
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            bad_k, at_lim: begin
              outp      <= 1'b0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            go_on: begin
              ptr  <= AW'(child);
              step <= step + SW'(1);
            end
            default: ;
          endcase
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_node_walker.sv
// Self-checking bench for dt_node_walker.
// Directed tree cases plus random tables against a behavioural walk model.
module tb_dt_node_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  inp;
  logic        out_valid;
  logic        out_ready;
  logic        outp;
  logic        out_err;
  logic        busy;

  int cmp = 0;
  int mis = 0;
  logic [15:0] mt [32];

  always #5 clk = ~clk;

  dt_node_walker dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready),
    .outp(outp), .out_err(out_err), .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mt[i] = 16'h0001;
  endtask

  // Walk the tree as described: follow children until a leaf,
  // a bad index, or the 16th internal visit; latency = visits + 2.
  function automatic void model_walk(
    input  logic [9:0] v,
    output logic       o,
    output logic       e,
    output int         lat
  );
    int p;
    p = 0; o = 1'b0; e = 1'b0; lat = 0;
    for (int s = 0; s < 16; s++) begin
      logic [15:0] n;
      int kk;
      n  = mt[p];
      kk = int'(n[5:2]);
      if (n[0]) begin
        o = n[1]; lat = s + 2; return;
      end
      if (kk >= 10 || s == 15) begin
        e = 1'b1; lat = s + 2; return;
      end
      p = v[kk] ? int'(n[15:11]) : int'(n[10:6]);
    end
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    mt[a] = d;
  endtask

  task automatic run_vec(
    input  logic [9:0] v,
    input  int         hold,
    output logic       o,
    output logic       e,
    output int         lat
  );
    @(negedge clk);
    inp = v; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inp = 10'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    o = outp; e = out_err;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic o, e;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cmp++;
    if ({in_ready, out_valid, outp, out_err, busy} !== 5'b10000) begin
      mis++;
      $display("FAIL reset_outs: got %b want 10000",
               {in_ready, out_valid, outp, out_err, busy});
    end
    run_vec(10'h3FF, 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b00 || lat != 2) begin
      mis++;
      $display("FAIL reset_walk: got o=%b e=%b lat=%0d want 0 0 2",
               o, e, lat);
    end
  endtask

  task automatic load_three_node();
    cfg_write(5'd0, 16'h1044);
    cfg_write(5'd1, 16'h0003);
    cfg_write(5'd2, 16'h0001);
  endtask

  task automatic test_three_node();
    logic o, e;
    int lat;
    load_three_node();
    run_vec(10'h000, 1, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b10 || lat != 3) begin
      mis++;
      $display("FAIL three_node_0: got o=%b e=%b lat=%0d want 1 0 3",
               o, e, lat);
    end
    run_vec(10'h002, 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b00 || lat != 3) begin
      mis++;
      $display("FAIL three_node_2: got o=%b e=%b lat=%0d want 0 0 3",
               o, e, lat);
    end
    cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      mis++;
      $display("FAIL idle_after: in_ready=%b busy=%b want 1 0",
               in_ready, busy);
    end
  endtask

  task automatic test_loop();
    logic o, e;
    int lat;
    cfg_write(5'd0, 16'h0000);
    run_vec(10'($urandom), 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b01 || lat != 17) begin
      mis++;
      $display("FAIL loop_limit: got o=%b e=%b lat=%0d want 0 1 17",
               o, e, lat);
    end
  endtask

  task automatic test_bad_feature();
    logic o, e;
    int lat;
    cfg_write(5'd0, 16'h0030);
    run_vec(10'h155, 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b01 || lat != 2) begin
      mis++;
      $display("FAIL bad_feature: got o=%b e=%b lat=%0d want 0 1 2",
               o, e, lat);
    end
  endtask

  task automatic test_backpressure();
    logic o, e;
    int lat;
    int first;
    first = 0;
    load_three_node();
    @(negedge clk);
    inp = 10'h000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inp = 10'h3FF;
    for (int c = 1; c <= 14; c++) begin
      cmp++;
      if (in_ready !== 1'b0) begin
        mis++;
        $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready);
      end
      if (out_valid === 1'b1) begin
        if (first == 0) first = c;
        cmp++;
        if ({outp, out_err} !== 2'b10) begin
          mis++;
          $display("FAIL bp_hold: cycle %0d got o=%b e=%b want 1 0",
                   c, outp, out_err);
        end
      end
      cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = 16'h0001;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    cmp++;
    if (first != 3) begin
      mis++;
      $display("FAIL bp_latency: got %0d want 3", first);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run_vec(10'h000, 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b10 || lat != 3) begin
      mis++;
      $display("FAIL bp_dropped_cfg: got o=%b e=%b lat=%0d want 1 0 3",
               o, e, lat);
    end
  endtask

  task automatic test_reset_mid_walk();
    logic o, e;
    int lat;
    cfg_write(5'd0, 16'h0000);
    @(negedge clk);
    inp = 10'h001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      mis++;
      $display("FAIL mid_reset_async: got %b want 010",
               {out_valid, in_ready, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mis++;
      $display("FAIL mid_reset_release: got %b want 01",
               {out_valid, in_ready});
    end
    run_vec(10'h3FF, 0, o, e, lat);
    cmp++;
    if ({o, e} !== 2'b00 || lat != 2) begin
      mis++;
      $display("FAIL mid_reset_table: got o=%b e=%b lat=%0d want 0 0 2",
               o, e, lat);
    end
  endtask

  task automatic test_random();
    logic o, e, xo, xe;
    int lat, xlat;
    logic [9:0] v;
    logic [15:0] w;
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 32; a++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          w[0] = 1'b1;
        end else begin
          w[0] = 1'b0;
          w[5:2] = 4'($urandom_range(0, 10));
        end
        cfg_write(5'(a), w);
      end
      for (int j = 0; j < 4; j++) begin
        v = 10'($urandom);
        model_walk(v, xo, xe, xlat);
        run_vec(v, $urandom_range(0, 3), o, e, lat);
        cmp++;
        if ({o, e} !== {xo, xe} || lat != xlat) begin
          mis++;
          $display("FAIL random_walk: v=%h got o=%b e=%b lat=%0d want %b %b %0d",
                   v, o, e, lat, xo, xe, xlat);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; inp = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_three_node();
    test_loop();
    test_bad_feature();
    test_backpressure();
    test_reset_mid_walk();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
